mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port `mem` instance between up to NUM_REQ bus masters: CPU, loader/DMA, debug port.
- Round-robin arbitration; one transaction at a time.
- Sequences the memory's one-cycle `rd`/`wr` strobes and its read latency.
- Returns a one-cycle `ack` with registered read data to the winning requester.
- Sits between the requesters and `mem`; the SoC top maps mem_addr/mem_wdata/mem_rdata onto the memory's address, data and out buses.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 16, memory address width.
- DATA_W, 32, data width.
- RD_LATENCY, 1, cycles from mem_rd strobe to valid mem_rdata (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester transaction request.
- req_wr  in  NUM_REQ  1 = write, 0 = read; per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rdata  out  DATA_W  read data, valid while any ack bit is high after a read.
- mem_rd  out  1  read strobe to memory.
- mem_wr  out  1  write strobe to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; ack, mem_rd, mem_wr, busy = 0; rdata, mem_addr, mem_wdata = 0; rr pointer = NUM_REQ-1.
  - Reset mid-transaction aborts it: strobes drop immediately, no ack is ever issued.
- Requester rules:
  - Hold req, req_wr, req_addr and req_wdata stable from assertion until the ack cycle.
  - req still high in the cycle after ack is a new request.
  - Dropping req before ack is illegal; the arbiter completes the transaction anyway.
- State machine IDLE -> ACCESS -> (WAIT) -> RESP -> IDLE:
  - IDLE: if any req bit is high at the clock edge, pick the winner and latch grant index, wr, addr and wdata; go to ACCESS.
  - ACCESS: exactly one cycle. mem_rd = !wr, mem_wr = wr; mem_addr and mem_wdata driven from the latched values. Writes go to RESP; reads go to WAIT.
  - WAIT: a down-counter starts at RD_LATENCY. On the edge where it reaches 1, capture mem_rdata into rdata and go to RESP.
  - RESP: ack[grant] = 1 for one cycle; the rr pointer is updated to grant; go to IDLE.
- Latency (request first sampled at edge k):
  - ACCESS occupies cycle k+1.
  - Write ack in cycle k+2.
  - Read ack in cycle k+2+RD_LATENCY.
  - Minimum spacing between transactions: 3 cycles for writes, 3+RD_LATENCY for reads.
- Arbitration:
  - Search starts at index (pointer+1) mod NUM_REQ and wraps; the first high req bit wins.
  - The pointer wraps from NUM_REQ-1 to 0.
  - Simultaneous requests after reset: requester 0 wins first.
- Signal rules:
  - mem_addr and mem_wdata hold their last values outside ACCESS.
  - Writes leave rdata unchanged.
  - mem_rd and mem_wr are never high together; each is high for exactly one cycle per transaction.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - Adds input `lock` [NUM_REQ].
  - If lock[grant] is high in RESP, that requester becomes owner. While owner's lock stays high, IDLE considers only owner's req; other requesters wait indefinitely.
  - Ownership is released in any IDLE cycle where owner's lock is low; normal round-robin resumes from the updated pointer.
  - Reset clears ownership.
- Undefined: the `lock` port is absent; pure round-robin.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, WAIT, RESP);
  - width constant for the grant index (max NUM_REQ 4 gives 2 bits);
  - latency-counter width.
- Sub-module rr_arbiter:
  - combinational round-robin pick;
  - inputs: req vector, pointer; outputs: grant index, any_req.
  - Parameterised by NUM_REQ. The FSM, pointer register and lock logic stay in mem_arbiter.

Test Plan:
- Single write: req[0]=1, wr=1, addr 0x0010, wdata 0xDEADBEEF at edge k -> mem_wr high cycle k+1 with those values; ack[0] in cycle k+2; busy low in cycle k+3.
- Single read, RD_LATENCY=1: req[1]=1, addr 0x0010 after the above write -> mem_rd in cycle k+1; ack[1] in cycle k+3 with rdata=0xDEADBEEF.
- Contention: req[0] and req[1] held high continuously with NUM_REQ=2 -> grants alternate 0,1,0,1; no requester is acked twice in a row.
- Wrap: NUM_REQ=4, pointer=3, req=4'b1001 -> requester 0 granted; next round with req=4'b1001 -> requester 3 granted.
- Reset mid-read: assert rst_n=0 during WAIT -> mem_rd, ack and busy drop in the same cycle; after release, the first req is serviced normally from IDLE.
- MEM_ARB_LOCK_EN: requester 1 holds lock with 3 back-to-back writes while req[0] is high -> requester 1 acked 3 times; req[0] is granted only after lock[1] drops.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the memory arbiter slice.
// Grant index is sized for the largest supported requester count (4).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int GNT_W = 2;
    localparam int LAT_W = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter; slave = arbiter view.
// The lock vector exists only when MEM_ARB_LOCK_EN is defined.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic                      mem_rd;
    logic                      mem_wr;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      busy;
`ifdef MEM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        lock;

    modport slave  (input  req, req_wr, req_addr, req_wdata, mem_rdata, lock,
                    output ack, rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy);
    modport master (output req, req_wr, req_addr, req_wdata, mem_rdata, lock,
                    input  ack, rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy);
`else
    modport slave  (input  req, req_wr, req_addr, req_wdata, mem_rdata,
                    output ack, rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy);
    modport master (output req, req_wr, req_addr, req_wdata, mem_rdata,
                    input  ack, rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy);
`endif
endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr and wraps.
// Latency: zero cycles; no backpressure, pure function of req and ptr.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GNT_W-1:0]   ptr,
    output logic [GNT_W-1:0]   gnt,
    output logic               any_req
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;

    always_comb begin
        dbl     = {req, req};
        // rot[0] is the requester right after ptr, so the lowest set bit wins
        rot     = NUM_REQ'(dbl >> (int'(ptr) + 1));
        gnt     = '0;
        any_req = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                gnt     = GNT_W'((int'(ptr) + 1 + j) % NUM_REQ);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory; optional bus locking via MEM_ARB_LOCK_EN.
// Latency: write ack 2 cycles, read ack 2+RD_LATENCY after req; losers simply keep req high.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    state_e               state_q, state_d;
    logic [GNT_W-1:0]     gnt_q, gnt_d;
    logic [GNT_W-1:0]     ptr_q, ptr_d;
    logic [LAT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 mem_rd_q, mem_rd_d;
    logic                 mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   req_eff;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [GNT_W-1:0]     arb_gnt;
    logic                 arb_any;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_wr;

    assign gnt_oh = NUM_REQ'(1) << gnt_q;

`ifdef MEM_ARB_LOCK_EN
    logic [GNT_W-1:0]     owner_q, owner_d;
    logic                 owner_vld_q, owner_vld_d;
    logic [NUM_REQ-1:0]   owner_oh;
    logic                 owner_hold;

    assign owner_oh   = NUM_REQ'(1) << owner_q;
    assign owner_hold = owner_vld_q && |(bus.lock & owner_oh);
    assign req_eff    = owner_hold ? (bus.req & owner_oh) : bus.req;
`else
    assign req_eff    = bus.req;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_eff),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .any_req (arb_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt == GNT_W'(i)) begin
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                sel_wr    = bus.req_wr[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_LOCK_EN
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MEM_ARB_LOCK_EN
                if (owner_vld_q && !owner_hold) owner_vld_d = 1'b0;
`endif
                if (arb_any) begin
                    gnt_d       = arb_gnt;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_wr_d    = sel_wr;
                    mem_rd_d    = !sel_wr;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_wr_q) begin
                    ack_d   = gnt_oh;
                    state_d = RESP;
                end else begin
                    cnt_d   = LAT_W'(RD_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAT_W'(1)) begin
                    rdata_d = bus.mem_rdata;
                    ack_d   = gnt_oh;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                ptr_d   = gnt_q;
                state_d = IDLE;
`ifdef MEM_ARB_LOCK_EN
                if (|(bus.lock & gnt_oh)) begin
                    owner_d     = gnt_q;
                    owner_vld_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ptr_q       <= GNT_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
`ifdef MEM_ARB_LOCK_EN
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
`endif
        end
    end

    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule
